// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a valid/ready pipeline register,
// with a RUN/HOLD/SLEEP FSM that serialises trap-class and WFI instructions.
module decode_stage #(
    parameter bit M_EXT  = 1'b1,
    parameter bit CSR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        op1sel,
    output logic        op2sel,
    output logic        reg_write_en,
    output logic [1:0]  wb_sel,
    output logic [4:0]  aluop,
    output logic [2:0]  branch_jump,
    output logic [2:0]  imm_sel,
    output logic [3:0]  read_write,
    output logic        csr_en,
    output logic        ecall,
    output logic        ebreak,
    output logic        mret,
    output logic        dret,
    output logic        wfi,
    output logic        illegal,
    input  logic        flush_i,
    input  logic        irq_pending_i,
    output logic        sleeping_o
);

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // imm_sel: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.  branch_jump: 0 none, 1 branch, 2 JAL, 3 JALR.
    // read_write: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW.
    typedef struct packed {
        logic       op1sel;
        logic       op2sel;
        logic       reg_write_en;
        logic [1:0] wb_sel;
        logic [4:0] aluop;
        logic [2:0] branch_jump;
        logic [2:0] imm_sel;
        logic [3:0] read_write;
        logic       csr_en;
        logic       ecall;
        logic       ebreak;
        logic       mret;
        logic       dret;
        logic       wfi;
        logic       illegal;
    } ctrl_t;

    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_SLEEP} state_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm12;
    logic        is_shift;
    ctrl_t       dec;
    ctrl_t       ctrl_q;
    state_t      state;
    logic        ready_en;
    logic        serial_q;
    logic        load;

    assign opcode   = in_instruction[6:0];
    assign funct3   = in_instruction[14:12];
    assign funct7   = in_instruction[31:25];
    assign imm12    = in_instruction[31:20];
    assign is_shift = (funct3[1:0] == 2'b01);

    // Control-field decode of the incoming word.
    always_comb begin
        dec = '0;
        unique case (opcode)
            OPC_LUI: begin
                dec.op2sel = 1'b1; dec.reg_write_en = 1'b1; dec.wb_sel = 2'd2; dec.imm_sel = 3'd4;
            end
            OPC_AUIPC: begin
                dec.op1sel = 1'b1; dec.op2sel = 1'b1; dec.reg_write_en = 1'b1; dec.imm_sel = 3'd4;
            end
            OPC_JAL: begin
                dec.op1sel = 1'b1; dec.op2sel = 1'b1; dec.reg_write_en = 1'b1;
                dec.wb_sel = 2'd3; dec.branch_jump = 3'd2; dec.imm_sel = 3'd5;
            end
            OPC_JALR: begin
                dec.op2sel = 1'b1; dec.reg_write_en = 1'b1;
                dec.wb_sel = 2'd3; dec.branch_jump = 3'd3; dec.imm_sel = 3'd1;
            end
            OPC_BRANCH: begin
                dec.branch_jump = 3'd1; dec.imm_sel = 3'd3;
            end
            OPC_LOAD: begin
                dec.op2sel = 1'b1; dec.reg_write_en = 1'b1; dec.wb_sel = 2'd1; dec.imm_sel = 3'd1;
                unique case (funct3)
                    3'b000:  dec.read_write = 4'd1;
                    3'b001:  dec.read_write = 4'd2;
                    3'b010:  dec.read_write = 4'd3;
                    3'b100:  dec.read_write = 4'd4;
                    3'b101:  dec.read_write = 4'd5;
                    default: dec.read_write = 4'd0;
                endcase
            end
            OPC_STORE: begin
                dec.op2sel = 1'b1; dec.imm_sel = 3'd2;
                unique case (funct3)
                    3'b000:  dec.read_write = 4'd6;
                    3'b001:  dec.read_write = 4'd7;
                    3'b010:  dec.read_write = 4'd8;
                    default: dec.read_write = 4'd0;
                endcase
            end
            OPC_OPIMM: begin
                dec.op2sel = 1'b1; dec.reg_write_en = 1'b1; dec.imm_sel = 3'd1;
                dec.aluop  = {funct3, is_shift & funct7[5], is_shift & funct7[0]};
            end
            OPC_OP: begin
                dec.reg_write_en = 1'b1;
                dec.aluop = {funct3, funct7[5], funct7[0]};
                if (!((funct7 == 7'b0000000) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                      (funct7 == 7'b0000001 && M_EXT))) begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    unique case (imm12)
                        12'h000: dec.ecall  = 1'b1;
                        12'h001: dec.ebreak = 1'b1;
                        12'h302: dec.mret   = 1'b1;
                        12'h7B2: dec.dret   = 1'b1;
                        12'h105: dec.wfi    = 1'b1;
                        default: dec.illegal = 1'b1;
                    endcase
                end else begin
                    dec.imm_sel = 3'd1; dec.reg_write_en = 1'b1; dec.csr_en = 1'b1;
                    if (funct3 == 3'b100 || !CSR_EN) begin
                        dec.illegal = 1'b1;
                    end
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        // An illegal word travels down the pipe but must not cause side effects.
        if (dec.illegal) begin
            dec.reg_write_en = 1'b0;
            dec.read_write   = 4'd0;
            dec.csr_en       = 1'b0;
            dec.ecall        = 1'b0;
            dec.ebreak       = 1'b0;
            dec.mret         = 1'b0;
            dec.dret         = 1'b0;
            dec.wfi          = 1'b0;
        end
    end

    assign serial_q = ctrl_q.ecall | ctrl_q.ebreak | ctrl_q.mret |
                      ctrl_q.dret  | ctrl_q.wfi    | ctrl_q.illegal;
    assign in_ready = ready_en && (state == ST_RUN) && (!out_valid || (out_ready && !serial_q));
    assign load     = in_valid && in_ready;

    // Pipeline register; flush beats a coincident load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            ctrl_q          <= '0;
            out_instruction <= '0;
            out_pc          <= '0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid       <= 1'b1;
            ctrl_q          <= dec;
            out_instruction <= XLEN'(in_instruction);
            out_pc          <= XLEN'(in_pc);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Serialisation FSM; ready_en keeps in_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush_i) begin
                state <= ST_RUN;
            end else begin
                unique case (state)
                    ST_RUN: begin
                        if (out_valid && out_ready && serial_q) begin
                            state <= ctrl_q.wfi ? ST_SLEEP : ST_HOLD;
                        end
                    end
                    ST_HOLD:  state <= ST_HOLD;
                    ST_SLEEP: if (irq_pending_i) state <= ST_RUN;
                    default:  state <= ST_RUN;
                endcase
            end
        end
    end

    assign sleeping_o   = (state == ST_SLEEP);
    assign op1sel       = ctrl_q.op1sel;
    assign op2sel       = ctrl_q.op2sel;
    assign reg_write_en = ctrl_q.reg_write_en;
    assign wb_sel       = ctrl_q.wb_sel;
    assign aluop        = ctrl_q.aluop;
    assign branch_jump  = ctrl_q.branch_jump;
    assign imm_sel      = ctrl_q.imm_sel;
    assign read_write   = ctrl_q.read_write;
    assign csr_en       = ctrl_q.csr_en;
    assign ecall        = ctrl_q.ecall;
    assign ebreak       = ctrl_q.ebreak;
    assign mret         = ctrl_q.mret;
    assign dret         = ctrl_q.dret;
    assign wfi          = ctrl_q.wfi;
    assign illegal      = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M/CSR enabled and disabled) share stimulus
// and are compared each cycle against an instruction-level reference model.
module tb_decode_stage;

    typedef struct packed {
        logic       op1sel;
        logic       op2sel;
        logic       reg_write_en;
        logic [1:0] wb_sel;
        logic [4:0] aluop;
        logic [2:0] branch_jump;
        logic [2:0] imm_sel;
        logic [3:0] read_write;
        logic       csr_en;
        logic       ecall;
        logic       ebreak;
        logic       mret;
        logic       dret;
        logic       wfi;
        logic       illegal;
    } ctrl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, flush_i, irq_pending_i;
    logic [31:0] in_instruction, in_pc;

    logic        d0_in_ready, d0_out_valid, d0_op1sel, d0_op2sel, d0_reg_write_en, d0_csr_en;
    logic        d0_ecall, d0_ebreak, d0_mret, d0_dret, d0_wfi, d0_illegal, d0_sleeping_o;
    logic [31:0] d0_out_instruction, d0_out_pc;
    logic [1:0]  d0_wb_sel;
    logic [4:0]  d0_aluop;
    logic [2:0]  d0_branch_jump, d0_imm_sel;
    logic [3:0]  d0_read_write;

    logic        d1_in_ready, d1_out_valid, d1_op1sel, d1_op2sel, d1_reg_write_en, d1_csr_en;
    logic        d1_ecall, d1_ebreak, d1_mret, d1_dret, d1_wfi, d1_illegal, d1_sleeping_o;
    logic [31:0] d1_out_instruction, d1_out_pc;
    logic [1:0]  d1_wb_sel;
    logic [4:0]  d1_aluop;
    logic [2:0]  d1_branch_jump, d1_imm_sel;
    logic [3:0]  d1_read_write;

    always #5 clk = ~clk;

    decode_stage #(.M_EXT(1'b1), .CSR_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d0_in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .out_valid(d0_out_valid),
        .out_ready(out_ready), .out_instruction(d0_out_instruction), .out_pc(d0_out_pc),
        .op1sel(d0_op1sel), .op2sel(d0_op2sel), .reg_write_en(d0_reg_write_en),
        .wb_sel(d0_wb_sel), .aluop(d0_aluop), .branch_jump(d0_branch_jump),
        .imm_sel(d0_imm_sel), .read_write(d0_read_write), .csr_en(d0_csr_en),
        .ecall(d0_ecall), .ebreak(d0_ebreak), .mret(d0_mret), .dret(d0_dret), .wfi(d0_wfi),
        .illegal(d0_illegal), .flush_i(flush_i), .irq_pending_i(irq_pending_i),
        .sleeping_o(d0_sleeping_o)
    );

    decode_stage #(.M_EXT(1'b0), .CSR_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d1_in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .out_valid(d1_out_valid),
        .out_ready(out_ready), .out_instruction(d1_out_instruction), .out_pc(d1_out_pc),
        .op1sel(d1_op1sel), .op2sel(d1_op2sel), .reg_write_en(d1_reg_write_en),
        .wb_sel(d1_wb_sel), .aluop(d1_aluop), .branch_jump(d1_branch_jump),
        .imm_sel(d1_imm_sel), .read_write(d1_read_write), .csr_en(d1_csr_en),
        .ecall(d1_ecall), .ebreak(d1_ebreak), .mret(d1_mret), .dret(d1_dret), .wfi(d1_wfi),
        .illegal(d1_illegal), .flush_i(flush_i), .irq_pending_i(irq_pending_i),
        .sleeping_o(d1_sleeping_o)
    );

    logic [26:0] obs_f [2];
    logic        obs_rdy [2];
    logic        obs_vld [2];
    logic        obs_slp [2];
    logic [31:0] obs_ins [2];
    logic [31:0] obs_pc [2];

    assign obs_f[0] = {d0_op1sel, d0_op2sel, d0_reg_write_en, d0_wb_sel, d0_aluop, d0_branch_jump,
                       d0_imm_sel, d0_read_write, d0_csr_en, d0_ecall, d0_ebreak, d0_mret,
                       d0_dret, d0_wfi, d0_illegal};
    assign obs_f[1] = {d1_op1sel, d1_op2sel, d1_reg_write_en, d1_wb_sel, d1_aluop, d1_branch_jump,
                       d1_imm_sel, d1_read_write, d1_csr_en, d1_ecall, d1_ebreak, d1_mret,
                       d1_dret, d1_wfi, d1_illegal};
    assign obs_rdy[0] = d0_in_ready;
    assign obs_rdy[1] = d1_in_ready;
    assign obs_vld[0] = d0_out_valid;
    assign obs_vld[1] = d1_out_valid;
    assign obs_slp[0] = d0_sleeping_o;
    assign obs_slp[1] = d1_sleeping_o;
    assign obs_ins[0] = d0_out_instruction;
    assign obs_ins[1] = d1_out_instruction;
    assign obs_pc[0]  = d0_out_pc;
    assign obs_pc[1]  = d1_out_pc;

    int checks = 0;
    int failures = 0;

    // Reference model state per instance; mode 0 = running, 1 = held, 2 = asleep.
    bit          m_started [2];
    int          m_mode [2];
    bit          m_valid [2];
    bit          m_rdy [2];
    ctrl_t       m_f [2];
    logic [31:0] m_ins [2];
    logic [31:0] m_pc [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_serial(input ctrl_t f);
        return f.ecall | f.ebreak | f.mret | f.dret | f.wfi | f.illegal;
    endfunction

    // Instruction-level decode written from the ISA rules.
    function automatic ctrl_t ref_decode(input logic [31:0] w, input bit m_ext, input bit csr_ok);
        ctrl_t f = '0;
        logic [6:0]  opc = w[6:0];
        logic [2:0]  f3  = w[14:12];
        logic [6:0]  f7  = w[31:25];
        logic [11:0] imm = w[31:20];
        bit lui = (opc == 7'h37), auipc = (opc == 7'h17), jal = (opc == 7'h6F);
        bit jalr = (opc == 7'h67), br = (opc == 7'h63), ld = (opc == 7'h03);
        bit st = (opc == 7'h23), opi = (opc == 7'h13), op = (opc == 7'h33), sys = (opc == 7'h73);
        bit csr = sys && (f3 != 3'b000);
        bit bad = !(lui || auipc || jal || jalr || br || ld || st || opi || op || sys);
        if (op && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && m_ext)))
            bad = 1;
        if (sys && f3 == 3'd0 && !(imm == 12'h000 || imm == 12'h001 || imm == 12'h302 ||
                                   imm == 12'h7B2 || imm == 12'h105))
            bad = 1;
        if (csr && (f3 == 3'd4 || !csr_ok)) bad = 1;
        f.illegal      = bad;
        f.op1sel       = auipc || jal;
        f.op2sel       = lui || auipc || jal || jalr || ld || st || opi;
        f.reg_write_en = !bad && (lui || auipc || jal || jalr || ld || opi || op || csr);
        f.wb_sel       = lui ? 2'd2 : (jal || jalr) ? 2'd3 : ld ? 2'd1 : 2'd0;
        if (op || (opi && (f3 == 3'd1 || f3 == 3'd5))) f.aluop = {f3, f7[5], f7[0]};
        else if (opi) f.aluop = {f3, 2'b00};
        f.branch_jump  = br ? 3'd1 : jal ? 3'd2 : jalr ? 3'd3 : 3'd0;
        f.imm_sel      = (opi || ld || jalr || csr) ? 3'd1 : st ? 3'd2 : br ? 3'd3 :
                         (lui || auipc) ? 3'd4 : jal ? 3'd5 : 3'd0;
        if (!bad && ld && f3 <= 3'd2) f.read_write = 4'(f3) + 4'd1;
        else if (!bad && ld && (f3 == 3'd4 || f3 == 3'd5)) f.read_write = 4'(f3);
        else if (!bad && st && f3 <= 3'd2) f.read_write = 4'(f3) + 4'd6;
        f.csr_en = csr && !bad;
        f.ecall  = sys && f3 == 3'd0 && imm == 12'h000;
        f.ebreak = sys && f3 == 3'd0 && imm == 12'h001;
        f.mret   = sys && f3 == 3'd0 && imm == 12'h302;
        f.dret   = sys && f3 == 3'd0 && imm == 12'h7B2;
        f.wfi    = sys && f3 == 3'd0 && imm == 12'h105;
        return f;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom;
        logic [6:0]  opcs [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        logic [11:0] sys_imm [6] = '{12'h000, 12'h001, 12'h302, 12'h7B2, 12'h105, 12'h30F};
        logic [6:0]  f7s [3] = '{7'h00, 7'h20, 7'h01};
        int unsigned k;
        case ($urandom_range(0, 9))
            0, 9: k = 0;
            7: begin
                w[6:0] = 7'h73; w[14:12] = 3'b000; w[31:20] = sys_imm[$urandom_range(0, 5)];
            end
            8: w[6:0] = 7'h73;
            default: begin
                w[6:0] = opcs[$urandom_range(0, 9)];
                k = $urandom_range(0, 3);
                if (k < 3) w[31:25] = f7s[k];
            end
        endcase
        return w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_started[k] = 0; m_mode[k] = 0; m_valid[k] = 0; m_rdy[k] = 0;
            m_f[k] = '0; m_ins[k] = '0; m_pc[k] = '0;
        end
    endtask

    task automatic reset_check(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_valid%0d", tag, k), 64'(obs_vld[k]), 64'd0);
            check($sformatf("%s_ready%0d", tag, k), 64'(obs_rdy[k]), 64'd0);
            check($sformatf("%s_fields%0d", tag, k), 64'(obs_f[k]), 64'd0);
            check($sformatf("%s_instr%0d", tag, k), 64'(obs_ins[k]), 64'd0);
            check($sformatf("%s_pc%0d", tag, k), 64'(obs_pc[k]), 64'd0);
            check($sformatf("%s_sleep%0d", tag, k), 64'(obs_slp[k]), 64'd0);
        end
    endtask

    // One clock: drive at negedge, check in_ready, advance model at posedge, check outputs.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                         input logic ordy, input logic fl, input logic irq);
        @(negedge clk);
        in_valid = iv; in_instruction = ins; in_pc = p;
        out_ready = ordy; flush_i = fl; irq_pending_i = irq;
        #1;
        for (int k = 0; k < 2; k++) begin
            m_rdy[k] = m_started[k] && m_mode[k] == 0 && (!m_valid[k] || (ordy && !is_serial(m_f[k])));
            check($sformatf("in_ready%0d", k), 64'(obs_rdy[k]), 64'(m_rdy[k]));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_started[k] = 1;
            if (fl) begin
                m_valid[k] = 0; m_mode[k] = 0;
            end else begin
                if (m_mode[k] == 0 && m_valid[k] && ordy && is_serial(m_f[k]))
                    m_mode[k] = m_f[k].wfi ? 2 : 1;
                else if (m_mode[k] == 2 && irq)
                    m_mode[k] = 0;
                if (iv && m_rdy[k]) begin
                    m_valid[k] = 1; m_f[k] = ref_decode(ins, k == 0, k == 0);
                    m_ins[k] = ins; m_pc[k] = p;
                end else if (ordy) begin
                    m_valid[k] = 0;
                end
            end
            check($sformatf("out_valid%0d", k), 64'(obs_vld[k]), 64'(m_valid[k]));
            check($sformatf("fields%0d", k), 64'(obs_f[k]), 64'(m_f[k]));
            check($sformatf("out_instr%0d", k), 64'(obs_ins[k]), 64'(m_ins[k]));
            check($sformatf("out_pc%0d", k), 64'(obs_pc[k]), 64'(m_pc[k]));
            check($sformatf("sleeping%0d", k), 64'(obs_slp[k]), 64'(m_mode[k] == 2));
        end
    endtask

    localparam logic [31:0] I_ADDI  = 32'h00100093;
    localparam logic [31:0] I_MUL   = 32'h022081B3;
    localparam logic [31:0] I_ADD   = 32'h00208133;
    localparam logic [31:0] I_WFI   = 32'h10500073;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_CSRRW = 32'h30001073;

    initial begin
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; flush_i = 0; irq_pending_i = 0;
        in_instruction = '0; in_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_check("reset");
        rst_n = 1'b1;

        cycle(0, '0, '0, 1, 0, 0);
        // Streaming
        cycle(1, I_ADDI, 32'h100, 1, 0, 0);
        check("addi_op2sel", 64'(d0_op2sel), 64'd1);
        check("addi_rwe", 64'(d0_reg_write_en), 64'd1);
        check("addi_aluop", 64'(d0_aluop), 64'd0);
        cycle(1, I_MUL, 32'h104, 1, 0, 0);
        check("mul_aluop", 64'(d0_aluop), 64'd1);
        check("mul_illegal_m", 64'(d0_illegal), 64'd0);
        check("mul_illegal_nom", 64'(d1_illegal), 64'd1);
        check("mul_rwe_nom", 64'(d1_reg_write_en), 64'd0);
        cycle(0, '0, '0, 1, 1, 0);
        // Backpressure
        cycle(1, I_ADDI, 32'h200, 0, 0, 0);
        repeat (3) cycle(1, I_ADD, 32'h204, 0, 0, 0);
        check("bp_in_ready", 64'(d0_in_ready), 64'd0);
        cycle(1, I_ADD, 32'h204, 1, 0, 0);
        check("bp_second_instr", 64'(d0_out_instruction), 64'(I_ADD));
        // WFI
        cycle(1, I_WFI, 32'h208, 1, 0, 0);
        check("wfi_flag", 64'(d0_wfi), 64'd1);
        cycle(1, I_ADDI, 32'h20C, 1, 0, 0);
        check("wfi_sleep", 64'(d0_sleeping_o), 64'd1);
        check("wfi_in_ready", 64'(d0_in_ready), 64'd0);
        cycle(1, I_ADDI, 32'h20C, 1, 0, 0);
        cycle(0, '0, '0, 1, 0, 1);
        check("wfi_wake", 64'(d0_in_ready), 64'd1);
        // ECALL
        cycle(1, I_ECALL, 32'h300, 0, 0, 0);
        check("ecall_flag", 64'(d0_ecall), 64'd1);
        cycle(0, '0, '0, 1, 0, 0);
        cycle(1, I_ADDI, 32'h304, 1, 0, 1);
        check("ecall_hold_irq", 64'(d0_in_ready), 64'd0);
        cycle(0, '0, '0, 1, 1, 0);
        check("ecall_release", 64'(d0_in_ready), 64'd1);
        // CSR and all-ones
        cycle(1, I_CSRRW, 32'h400, 1, 0, 0);
        check("csr_en", 64'(d0_csr_en), 64'd1);
        check("csr_illegal_nocsr", 64'(d1_illegal), 64'd1);
        cycle(1, 32'hFFFF_FFFF, 32'h404, 1, 0, 0);
        check("ones_illegal", 64'(d0_illegal), 64'd1);
        check("ones_rw", 64'(d0_read_write), 64'd0);
        cycle(0, '0, '0, 1, 1, 0);
        // Flush beats a coincident load
        cycle(1, I_ADDI, 32'h500, 1, 1, 0);
        check("flush_load", 64'(d0_out_valid), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1 reset_check("midreset");
                model_reset();
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            cycle($urandom_range(0, 9) < 7, gen_instr(), $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 6) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I decode stage with a valid/ready pipeline register between fetch and execute. It generates the core's standard control fields and optionally decodes the M and Zicsr extensions. It also detects illegal instructions and serialises SYSTEM-class instructions. A three-state FSM stalls fetch after trap-class instructions until a flush arrives, and after WFI until an interrupt is pending.

## Interface
- M_EXT, 1: 1 = R-type funct7=0000001 (MUL/DIV family) is legal; 0 = illegal.
- CSR_EN, 1: 1 = SYSTEM funct3≠000 decodes as CSR; 0 = illegal.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid / in_ready  in / out  1  fetch handshake.
- in_instruction, in_pc  in  32 each  fetched word and its PC.
- out_valid / out_ready  out / in  1  execute handshake.
- out_instruction, out_pc  out  32 each  registered copies.
- op1sel, op2sel, reg_write_en  out  1 each.
- wb_sel  out  2  00 ALU, 01 load, 10 imm (LUI), 11 PC+4.
- aluop  out  5  {funct3, funct7[5], funct7[0]} for OP/OP-IMM.
  - The funct7 bits are used only for R-type and I-shifts (funct3 001/101).
  - All bits are 0 for other opcodes.
- branch_jump, imm_sel  out  3 each  standard core encodings.
- read_write  out  4  standard memory-command encoding.
- csr_en  out  1  valid CSR instruction (CSR_EN=1 only).
- ecall, ebreak, mret, dret, wfi  out  1 each  SYSTEM funct3=000 with imm12 = 000 / 001 / 302 / 7B2 / 105 respectively.
- illegal  out  1  registered instruction is illegal.
- flush_i  in  1  redirect from execute: kills the register and releases the stall.
- irq_pending_i  in  1  wakes the stage from WFI.
- sleeping_o  out  1  FSM is in SLEEP.

## Operation
- Decode is combinational on in_instruction; all outputs come from the pipeline register.
- Reset value of every output is 0, except in_ready, which becomes 1 one cycle after reset releases (FSM enters RUN, register empty).
- **Illegal instruction** — any of:
  - opcode[1:0]≠11;
  - opcode not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM;
  - R-type funct7 not in {0000000, 0100000 with funct3∈{000,101}, 0000001 if M_EXT};
  - SYSTEM funct3=000 with an unlisted imm12;
  - SYSTEM funct3=100;
  - SYSTEM funct3≠000 when CSR_EN=0.
- An illegal instruction forces reg_write_en=0, read_write=0, csr_en=0 and all SYSTEM flags to 0. It still propagates, with illegal=1.
- **Serialising instruction** = ecall | ebreak | mret | dret | wfi | illegal.
- **FSM states:**
  - RUN: in_ready = !out_valid | (out_ready & !serial_q), where serial_q is the serialising flag of the registered instruction.
  - HOLD: in_ready=0.
  - SLEEP: in_ready=0; sleeping_o=1.
- **Transitions:**
  - RUN→SLEEP when a registered WFI is accepted (out_valid & out_ready).
  - RUN→HOLD when any other serialising instruction is accepted.
  - HOLD→RUN on flush_i only.
  - SLEEP→RUN on irq_pending_i or flush_i.
- **Load:** in_valid & in_ready captures the instruction, PC and decoded fields, and sets out_valid.
- **Drain:** out_ready with no load clears out_valid.
- **Flush:**
  - Clears out_valid and forces RUN from any state.
  - Flush wins over a simultaneous load; the incoming word is dropped.
  - Flush wins over a simultaneous acceptance of a serialising instruction (no HOLD/SLEEP entry).
- **Stall stability:** while out_valid & !out_ready, all outputs are held stable.
- **Reset mid-operation:** reset asserted at any time returns to RUN with empty register and all outputs 0, asynchronously.

## Timing
- Latency: one cycle from in_valid & in_ready to out_valid.
- Throughput: one instruction per cycle in RUN with out_ready held high.
- in_ready is combinational from out_ready and state; there is no combinational path from in_valid to out_valid.
- After a serialising instruction is accepted, in_ready stays 0 from that cycle onward.
- Wake from SLEEP: irq_pending_i high in cycle N → in_ready high in cycle N+1.
- Release from HOLD: flush_i high in cycle N → in_ready high in cycle N+1.
- irq_pending_i is ignored in RUN and HOLD.

## Test plan
- **Streaming:** 0x00100093 (addi) then 0x022081B3 (mul) with out_ready=1 → out_valid one cycle after each load.
  - addi: op2sel=1, reg_write_en=1, aluop=00000.
  - mul: aluop=00001, illegal=0.
  - With M_EXT=0, mul → illegal=1, reg_write_en=0.
- **Backpressure:** out_ready=0 for 3 cycles with a word registered → in_ready=0 and outputs stable; a 2nd word is loaded the same cycle out_ready returns to 1.
- **WFI:** load 0x10500073 → wfi=1. On acceptance, sleeping_o=1 and in_ready=0 even with in_valid=1. irq_pending_i pulse → in_ready=1 next cycle.
- **ECALL:** load 0x00000073 → ecall=1. After acceptance, HOLD; irq_pending_i has no effect. flush_i → RUN next cycle.
- **CSR:** 0x30001073 (csrrw) → csr_en=1 with CSR_EN=1; illegal=1 with CSR_EN=0. 0xFFFFFFFF → illegal=1, read_write=0.
- **Corner cases:**
  - flush_i coincident with a load: out_valid=0 next cycle.
  - rst_n asserted mid-stream: outputs 0 immediately.
